core_ctrl_fsm: RTL
==================

CORE_CTRL_FSM -- requirements
Module: core_ctrl_fsm

Interface
REQ-001 SHALL provide ports: clk  in  1  single clock, rising edge; all state updates on this edge.
REQ-002 SHALL provide: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL provide: imem_req  out  1  instruction fetch request; imem_ready  in  1  fetch data valid; imem_rdata  in  32  fetched instruction.
REQ-004 SHALL provide: instr_q  out  32  latched instruction register, feeds immediate/decode datapath.
REQ-005 SHALL provide: dmem_req  out  1  data access request; dmem_we  out  1  store when 1; dmem_ack  in  1  access complete.
REQ-006 SHALL provide: alu_src_imm  out  1  ALU operand B from immediate; rf_we  out  1  register write; pc_we  out  1  PC update strobe; trap  out  1  illegal instruction, sticky.
REQ-007 SHALL provide: state  out  3  current FSM state encoding, for debug.

Function
REQ-008 SHALL implement Moore FSM: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; encodings 6-7 SHALL go to TRAP.
REQ-009 SHALL drive all outputs only from state and instr_q (no combinational input-to-output path).
REQ-010 FETCH: imem_req=1; hold until imem_ready=1, then instr_q<=imem_rdata and go to DECODE.
REQ-011 DECODE: exactly one cycle; legal opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE go to EXEC; any other instr_q[6:0] goes to TRAP.
REQ-012 EXEC: alu_src_imm=1 for OP-IMM, LOAD, STORE, JALR, LUI, AUIPC, JAL; 0 otherwise; LOAD/STORE go to MEM, BRANCH asserts pc_we=1 and goes to FETCH, all others go to WB.
REQ-013 MEM: dmem_req=1, dmem_we=1 only for STORE; held until dmem_ack=1; on ack LOAD goes to WB, STORE asserts pc_we=1 and goes to FETCH.
REQ-014 WB: pc_we=1; rf_we=1 unless rd (instr_q[11:7])=0 or opcode is FENCE; then FETCH.
REQ-015 TRAP: trap=1, every request and strobe 0, remains until reset.
REQ-016 Latency with zero-wait memories: branch 3 cycles, ALU/jump/store 4, load 5.
REQ-017 imem_ready outside FETCH and dmem_ack outside MEM SHALL be ignored; pc_we and rf_we SHALL each pulse at most one cycle per instruction.

Reset
REQ-018 rst_n=0 SHALL immediately force state=FETCH, instr_q=0, all outputs 0 except imem_req.
REQ-019 imem_req SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-020 Reset mid-instruction SHALL abort it with no pc_we, rf_we or dmem_req pulse.

Configuration
REQ-021 Macro CORE_CTRL_INSTRET_EN defined: add output instret  out  32, reset 0, incrementing by 1 on each pc_we pulse and wrapping 0xFFFFFFFF->0.
REQ-022 Macro undefined: no instret port and no counter logic; all other behaviour identical.

Structure
REQ-023 Shared package SHALL hold ctrl_state_t enum and 7-bit opcode constants (OPC_LUI ... OPC_FENCE).
REQ-024 Opcode classification (legal, is_load, is_store, is_branch, uses_imm) SHALL live in combinational sub-module ctrl_opcode_dec.

Verification
REQ-025 ADDI x1,x0,5 (0x00500093), imem_ready=1 -> states 0,1,2,4; cycle 4 rf_we=1, pc_we=1.
REQ-026 ADDI x0,x0,0 (0x00000013) -> WB with rf_we=0, pc_we=1.
REQ-027 SW (0x00112223), dmem_ack 3 cycles late -> dmem_req=dmem_we=1 for 4 cycles, pc_we on ack cycle, rf_we never.
REQ-028 LW (0x0000A083), dmem_ack immediate -> MEM then WB rf_we=1; total 5 cycles.
REQ-029 BEQ (0x00000063) -> pc_we in EXEC, FETCH on cycle 4; 0xFFFFFFFF -> trap=1 held 10+ cycles, imem_req=0; rst_n pulse recovers to FETCH.
REQ-030 rst_n=0 during MEM with dmem_req=1 -> dmem_req=0 same cycle; with CORE_CTRL_INSTRET_EN, instret=0 and counts 3 after three ADDIs.

Source files
------------

// File: rtl/core_ctrl_fsm_pkg.sv
// Shared types for the multi-cycle core controller: state encoding and
// RV32I major-opcode constants.
package core_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } ctrl_state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // x0 is hard-wired and FENCE has no destination, so neither writes the RF.
  function automatic logic writes_rd(input logic [4:0] rd, input logic [6:0] opc);
    return (rd != 5'd0) && (opc != OPC_FENCE);
  endfunction

endpackage

// File: rtl/core_ctrl_fsm_opcode_dec.sv
// Combinational major-opcode classifier for core_ctrl_fsm.
module ctrl_opcode_dec
  import core_ctrl_fsm_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_legal,
  output logic       o_is_load,
  output logic       o_is_store,
  output logic       o_is_branch,
  output logic       o_uses_imm
);

  always_comb begin
    o_legal     = 1'b1;
    o_is_load   = 1'b0;
    o_is_store  = 1'b0;
    o_is_branch = 1'b0;
    o_uses_imm  = 1'b0;
    case (i_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM: o_uses_imm = 1'b1;
      OPC_LOAD: begin
        o_is_load  = 1'b1;
        o_uses_imm = 1'b1;
      end
      OPC_STORE: begin
        o_is_store = 1'b1;
        o_uses_imm = 1'b1;
      end
      OPC_BRANCH:        o_is_branch = 1'b1;
      OPC_OP, OPC_FENCE: o_legal     = 1'b1;
      default:           o_legal     = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle Moore controller (FETCH/DECODE/EXEC/MEM/WB/TRAP), all outputs registered.
// Define CORE_CTRL_INSTRET_EN to add the 32-bit retired-instruction counter output instret.
module core_ctrl_fsm
  import core_ctrl_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_q,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        alu_src_imm,
  output logic        rf_we,
  output logic        pc_we,
  output logic        trap,
  output logic [2:0]  state
`ifdef CORE_CTRL_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  ctrl_state_t r_state;
  logic [31:0] r_instr;
  logic        r_imem_req, r_dmem_req, r_dmem_we, r_alu_src_imm;
  logic        r_rf_we, r_pc_we, r_trap;
  logic        w_legal, w_is_load, w_is_store, w_is_branch, w_uses_imm;

  ctrl_opcode_dec u_dec (
    .i_opcode   (r_instr[6:0]),
    .o_legal    (w_legal),
    .o_is_load  (w_is_load),
    .o_is_store (w_is_store),
    .o_is_branch(w_is_branch),
    .o_uses_imm (w_uses_imm)
  );

  // Outputs are registered alongside the state they belong to, so each branch
  // loads the output values of the state being entered. Strobes default low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_instr       <= '0;
      r_imem_req    <= 1'b0;
      r_dmem_req    <= 1'b0;
      r_dmem_we     <= 1'b0;
      r_alu_src_imm <= 1'b0;
      r_rf_we       <= 1'b0;
      r_pc_we       <= 1'b0;
      r_trap        <= 1'b0;
    end else begin
      r_imem_req    <= 1'b0;
      r_dmem_req    <= 1'b0;
      r_dmem_we     <= 1'b0;
      r_alu_src_imm <= 1'b0;
      r_rf_we       <= 1'b0;
      r_pc_we       <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          // A ready only counts once the request is actually out (not in the
          // first cycle after reset release).
          if (r_imem_req && imem_ready) begin
            r_instr <= imem_rdata;
            r_state <= ST_DECODE;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (w_legal) begin
            r_state       <= ST_EXEC;
            r_alu_src_imm <= w_uses_imm;
            r_pc_we       <= w_is_branch;
          end else begin
            r_state <= ST_TRAP;
            r_trap  <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (w_is_branch) begin
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end else if (w_is_load || w_is_store) begin
            r_state    <= ST_MEM;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= w_is_store;
          end else begin
            r_state <= ST_WB;
            r_pc_we <= 1'b1;
            r_rf_we <= writes_rd(r_instr[11:7], r_instr[6:0]);
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (w_is_store) begin
              // Store retires here; its PC strobe lands in the next FETCH cycle.
              r_state    <= ST_FETCH;
              r_imem_req <= 1'b1;
              r_pc_we    <= 1'b1;
            end else begin
              r_state <= ST_WB;
              r_pc_we <= 1'b1;
              r_rf_we <= writes_rd(r_instr[11:7], r_instr[6:0]);
            end
          end else begin
            r_dmem_req <= 1'b1;
            r_dmem_we  <= w_is_store;
          end
        end
        ST_WB: begin
          r_state    <= ST_FETCH;
          r_imem_req <= 1'b1;
        end
        ST_TRAP: r_trap <= 1'b1;
        default: begin
          r_state <= ST_TRAP;
          r_trap  <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign instr_q     = r_instr;
  assign dmem_req    = r_dmem_req;
  assign dmem_we     = r_dmem_we;
  assign alu_src_imm = r_alu_src_imm;
  assign rf_we       = r_rf_we;
  assign pc_we       = r_pc_we;
  assign trap        = r_trap;
  assign state       = r_state;

`ifdef CORE_CTRL_INSTRET_EN
  logic [31:0] r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_instret <= '0;
    else        r_instret <= r_instret + {31'd0, r_pc_we};
  end

  assign instret = r_instret;
`endif

endmodule
